// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command decoder:
//   - command symbol constants (8-bit encoded line symbols)
//   - 8b->5b data symbol decode function
//   - command classification helpers
//   - decoder FSM state typedef
// -----------------------------------------------------------------------------
package cmd_pkg;

   localparam logic [7:0] SYM_CLEAR  = 8'h5A;
   localparam logic [7:0] SYM_PULSE  = 8'h5C;
   localparam logic [7:0] SYM_CAL    = 8'h63;
   localparam logic [7:0] SYM_NOOP   = 8'hAA;
   localparam logic [7:0] SYM_WRREG  = 8'h66;
   localparam logic [7:0] SYM_RDREG  = 8'h65;
   localparam logic [7:0] SYM_SYNC_A = 8'h81;
   localparam logic [7:0] SYM_SYNC_B = 8'h7E;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int CAL_W  = 15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC1,
      S_ID,
      S_CAL_D,
      S_WR_ADDR_H,
      S_WR_ADDR_L,
      S_WR_CNT,
      S_WR_DATA,
      S_RD_ADDR_H,
      S_RD_ADDR_L
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] value;
   } dec_t;

   // 8b->5b data symbol decode; valid=0 for anything outside the table.
   function automatic dec_t decode_sym(input logic [7:0] sym);
      dec_t r;
      r.valid = 1'b1;
      r.value = 5'd0;
      case (sym)
         8'h6A: r.value = 5'd0;
         8'h6C: r.value = 5'd1;
         8'h71: r.value = 5'd2;
         8'h72: r.value = 5'd3;
         8'h74: r.value = 5'd4;
         8'h8B: r.value = 5'd5;
         8'h8D: r.value = 5'd6;
         8'h8E: r.value = 5'd7;
         8'h93: r.value = 5'd8;
         8'h95: r.value = 5'd9;
         8'h96: r.value = 5'd10;
         8'h99: r.value = 5'd11;
         8'h9A: r.value = 5'd12;
         8'h9C: r.value = 5'd13;
         8'hA3: r.value = 5'd14;
         8'hA5: r.value = 5'd15;
         8'hA6: r.value = 5'd16;
         8'hA9: r.value = 5'd17;
         8'h59: r.value = 5'd18;
         8'hAC: r.value = 5'd19;
         8'hB1: r.value = 5'd20;
         8'hB2: r.value = 5'd21;
         8'hB4: r.value = 5'd22;
         8'hC3: r.value = 5'd23;
         8'hC5: r.value = 5'd24;
         8'hC6: r.value = 5'd25;
         8'hC9: r.value = 5'd26;
         8'hCA: r.value = 5'd27;
         8'hCC: r.value = 5'd28;
         8'hD1: r.value = 5'd29;
         8'hD2: r.value = 5'd30;
         8'hD4: r.value = 5'd31;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

   // Any symbol with command meaning, including the sync tail and NOOP.
   function automatic logic is_cmd_sym(input logic [7:0] sym);
      return (sym == SYM_CLEAR) || (sym == SYM_PULSE) || (sym == SYM_CAL) ||
             (sym == SYM_NOOP)  || (sym == SYM_WRREG) || (sym == SYM_RDREG) ||
             (sym == SYM_SYNC_A) || (sym == SYM_SYNC_B);
   endfunction

   // Symbols that open a new frame (and abort any frame in progress).
   function automatic logic is_start_sym(input logic [7:0] sym);
      return (sym == SYM_CLEAR) || (sym == SYM_PULSE) || (sym == SYM_CAL) ||
             (sym == SYM_WRREG) || (sym == SYM_RDREG) || (sym == SYM_SYNC_A);
   endfunction

endpackage

// File: rtl/rd_req_fifo.sv
// -----------------------------------------------------------------------------
// rd_req_fifo
// Read-request address FIFO. A push while full is dropped and reported with a
// one-cycle overflow pulse, unless a pop happens on the same edge, in which
// case the freed slot takes the new entry.
// Ports:
//   clk80, reset        clock, async active-high reset
//   push, push_data     write request
//   pop                 consume head (ignored when empty)
//   pop_data            head entry, 0 when empty
//   valid               FIFO non-empty
//   overflow            one-cycle pulse, push dropped
// -----------------------------------------------------------------------------
module rd_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk80,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign valid    = ~empty;
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push & ~do_push;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk80) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cmd_decoder_mc.sv
// -----------------------------------------------------------------------------
// cmd_decoder_mc
// Decodes an 8-bit encoded symbol stream into chip commands, register writes,
// queued register-read requests and sync strobes for a range of chip IDs.
// Ports:
//   clk80, reset                       clock, async active-high reset
//   data_in_valid, data_in             symbol strobe and symbol
//   chip_id_base                       lowest served chip ID
//   clear, pulse, cal, sync            one-cycle command strobes
//   chip_hit                           target mask, valid with any strobe
//   cal_data                           {D1,D2,D3} of the last CAL
//   wr_valid, wr_addr, wr_data         register write strobe and payload
//   rd_valid, rd_ready, rd_addr        read-request queue head handshake
//   rd_overflow                        one-cycle pulse, read request dropped
//   err_count                          saturating protocol error count
// rd_valid/rd_ready: the head entry rd_addr is held stable while rd_valid=1;
// it is consumed on every clock edge where rd_valid and rd_ready are both 1.
// -----------------------------------------------------------------------------
module cmd_decoder_mc #(
   parameter int NUM_CHIPS = 1,
   parameter int RDQ_DEPTH = 4,
   parameter int ERR_W     = 8
) (
   input  logic                 clk80,
   input  logic                 reset,
   input  logic                 data_in_valid,
   input  logic [7:0]           data_in,
   input  logic [3:0]           chip_id_base,
   output logic                 clear,
   output logic                 pulse,
   output logic                 cal,
   output logic [NUM_CHIPS-1:0] chip_hit,
   output logic [14:0]          cal_data,
   output logic                 sync,
   output logic                 wr_valid,
   output logic [8:0]           wr_addr,
   output logic [15:0]          wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [8:0]           rd_addr,
   output logic                 rd_overflow,
   output logic [ERR_W-1:0]     err_count
);

   import cmd_pkg::*;

   state_t                 state;
   logic [7:0]             last_sym;
   logic [7:0]             cur_cmd;
   logic [1:0]             fld;
   logic [4:0]             cal_d1;
   logic [4:0]             cal_d2;
   logic                   burst;
   logic [3:0]             addr_h;
   logic [8:0]             cur_addr;
   logic [4:0]             words_left;
   logic [14:0]            wr_acc;
   logic                   rd_push;
   logic [8:0]             rd_push_addr;

   dec_t                   dec;
   logic                   is_data;
   logic [4:0]             d;
   logic [3:0]             id_diff;
   logic [NUM_CHIPS-1:0]   hit_mask;
   logic [NUM_CHIPS-1:0]   id_mask;
   logic                   id_hit;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // ID match: the 4-bit difference wraps mod 16 so a base near 15 can
   // serve IDs 0.. as well.
   always_comb begin
      dec     = decode_sym(data_in);
      is_data = dec.valid;
      d       = dec.value;
      id_diff = d[3:0] - chip_id_base;
      hit_mask = '0;
      for (int k = 0; k < NUM_CHIPS; k++) begin
         hit_mask[k] = (id_diff == 4'(k));
      end
      id_mask = d[4] ? '1 : hit_mask;
      id_hit  = |id_mask;
   end

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         last_sym     <= 8'h00;
         cur_cmd      <= 8'h00;
         fld          <= 2'd0;
         cal_d1       <= 5'd0;
         cal_d2       <= 5'd0;
         burst        <= 1'b0;
         addr_h       <= 4'd0;
         cur_addr     <= 9'd0;
         words_left   <= 5'd0;
         wr_acc       <= 15'd0;
         rd_push      <= 1'b0;
         rd_push_addr <= 9'd0;
         clear        <= 1'b0;
         pulse        <= 1'b0;
         cal          <= 1'b0;
         sync         <= 1'b0;
         wr_valid     <= 1'b0;
         chip_hit     <= '0;
         cal_data     <= 15'd0;
         wr_addr      <= 9'd0;
         wr_data      <= 16'd0;
         err_count    <= '0;
      end else begin
         clear    <= 1'b0;
         pulse    <= 1'b0;
         cal      <= 1'b0;
         sync     <= 1'b0;
         wr_valid <= 1'b0;
         rd_push  <= 1'b0;
         if (data_in_valid) begin
            last_sym <= data_in;
            if (is_cmd_sym(data_in) && (data_in == last_sym)) begin
               // Repeated command symbol: same command, nothing to do.
            end else if (data_in == SYM_NOOP) begin
               // NOOP is transparent, even inside a frame.
            end else if ((state == S_SYNC1) && (data_in == SYM_SYNC_B)) begin
               sync  <= 1'b1;
               state <= S_IDLE;
            end else if (is_start_sym(data_in)) begin
               // New command always wins; interrupting a frame is an error.
               if (state != S_IDLE) err_count <= sat_inc(err_count);
               cur_cmd <= data_in;
               state   <= (data_in == SYM_SYNC_A) ? S_SYNC1 : S_ID;
            end else if ((state == S_IDLE) || (state == S_SYNC1) || !is_data) begin
               err_count <= sat_inc(err_count);
               state     <= S_IDLE;
            end else begin
               case (state)
                  S_ID: begin
                     if (!id_hit) begin
                        state <= S_IDLE;
                     end else begin
                        chip_hit <= id_mask;
                        case (cur_cmd)
                           SYM_CLEAR: begin
                              clear <= 1'b1;
                              state <= S_IDLE;
                           end
                           SYM_PULSE: begin
                              pulse <= 1'b1;
                              state <= S_IDLE;
                           end
                           SYM_CAL: begin
                              fld   <= 2'd0;
                              state <= S_CAL_D;
                           end
                           SYM_WRREG: state <= S_WR_ADDR_H;
                           SYM_RDREG: state <= S_RD_ADDR_H;
                           default:   state <= S_IDLE;
                        endcase
                     end
                  end
                  S_CAL_D: begin
                     fld <= fld + 2'd1;
                     if (fld == 2'd0) begin
                        cal_d1 <= d;
                     end else if (fld == 2'd1) begin
                        cal_d2 <= d;
                     end else begin
                        cal_data <= {cal_d1, cal_d2, d};
                        cal      <= 1'b1;
                        state    <= S_IDLE;
                     end
                  end
                  S_WR_ADDR_H: begin
                     burst  <= d[4];
                     addr_h <= d[3:0];
                     state  <= S_WR_ADDR_L;
                  end
                  S_WR_ADDR_L: begin
                     cur_addr   <= {addr_h, d};
                     fld        <= 2'd0;
                     words_left <= 5'd0;
                     state      <= burst ? S_WR_CNT : S_WR_DATA;
                  end
                  S_WR_CNT: begin
                     // N means N+1 words follow.
                     words_left <= d;
                     state      <= S_WR_DATA;
                  end
                  S_WR_DATA: begin
                     fld <= fld + 2'd1;
                     case (fld)
                        2'd0: wr_acc[14:10] <= d;
                        2'd1: wr_acc[9:5]   <= d;
                        2'd2: wr_acc[4:0]   <= d;
                        default: begin
                           // Last field carries only data[0] in its MSB.
                           wr_valid <= 1'b1;
                           wr_addr  <= cur_addr;
                           wr_data  <= {wr_acc, d[4]};
                           cur_addr <= cur_addr + 9'd1;
                           if (words_left == 5'd0) state <= S_IDLE;
                           else words_left <= words_left - 5'd1;
                        end
                     endcase
                  end
                  S_RD_ADDR_H: begin
                     addr_h <= d[3:0];
                     state  <= S_RD_ADDR_L;
                  end
                  S_RD_ADDR_L: begin
                     rd_push      <= 1'b1;
                     rd_push_addr <= {addr_h, d};
                     state        <= S_IDLE;
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

   rd_req_fifo #(
      .DEPTH (RDQ_DEPTH),
      .WIDTH (ADDR_W)
   ) u_rd_req_fifo (
      .clk80     (clk80),
      .reset     (reset),
      .push      (rd_push),
      .push_data (rd_push_addr),
      .pop       (rd_valid & rd_ready),
      .pop_data  (rd_addr),
      .valid     (rd_valid),
      .overflow  (rd_overflow)
   );

endmodule

// File: tb/tb_cmd_decoder_mc.sv
// -----------------------------------------------------------------------------
// tb_cmd_decoder_mc
// Directed-vector bench for cmd_decoder_mc (NUM_CHIPS=4, RDQ_DEPTH=4, ERR_W=8).
// Stimulus pushes the expected output events into exp_q; a negedge monitor
// pops and compares whenever the DUT raises a strobe or a read is consumed.
// -----------------------------------------------------------------------------
module tb_cmd_decoder_mc;

   localparam int NC    = 4;
   localparam int DEPTH = 4;
   localparam int EW    = 8;

   localparam logic [3:0] K_CLEAR = 4'd1;
   localparam logic [3:0] K_PULSE = 4'd2;
   localparam logic [3:0] K_CAL   = 4'd3;
   localparam logic [3:0] K_SYNC  = 4'd4;
   localparam logic [3:0] K_WR    = 4'd5;
   localparam logic [3:0] K_OVF   = 4'd6;
   localparam logic [3:0] K_POP   = 4'd7;

   logic          clk80 = 1'b0;
   logic          reset = 1'b1;
   logic          data_in_valid = 1'b0;
   logic [7:0]    data_in = 8'h00;
   logic [3:0]    chip_id_base = 4'd0;
   logic          rd_ready = 1'b0;
   logic          clear, pulse, cal, sync, wr_valid, rd_valid, rd_overflow;
   logic [NC-1:0] chip_hit;
   logic [14:0]   cal_data;
   logic [8:0]    wr_addr, rd_addr;
   logic [15:0]   wr_data;
   logic [EW-1:0] err_count;

   logic [31:0]   exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [7:0]    enc [32];

   cmd_decoder_mc #(
      .NUM_CHIPS (NC),
      .RDQ_DEPTH (DEPTH),
      .ERR_W     (EW)
   ) dut (
      .clk80         (clk80),
      .reset         (reset),
      .data_in_valid (data_in_valid),
      .data_in       (data_in),
      .chip_id_base  (chip_id_base),
      .clear         (clear),
      .pulse         (pulse),
      .cal           (cal),
      .chip_hit      (chip_hit),
      .cal_data      (cal_data),
      .sync          (sync),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_overflow   (rd_overflow),
      .err_count     (err_count)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk80 = ~clk80;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [31:0] ev(input logic [3:0] k, input logic [27:0] p);
      return {k, p};
   endfunction

   task automatic expect_ev(input logic [3:0] k, input logic [27:0] p);
      exp_q.push_back(ev(k, p));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk80);
         #1;
      end
   endtask

   // One symbol for one cycle, then 'gap' cycles with valid low and junk data.
   task automatic send(input logic [7:0] s, input int gap);
      data_in       = s;
      data_in_valid = 1'b1;
      @(posedge clk80);
      #1;
      data_in_valid = 1'b0;
      data_in       = 8'($urandom_range(0, 255));
      idle(gap);
   endtask

   task automatic send_d(input int v, input int gap);
      send(enc[v], gap);
   endtask

   // RDREG to ID 0 with address fields hi (addr[8:5]) and lo (addr[4:0]).
   task automatic rd_frame(input int hi, input int lo, input int gap);
      send(8'h65, gap);
      send_d(0, gap);
      send_d(hi, gap);
      send_d(lo, gap);
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic mon_ev(input string name, input logic [31:0] got);
      logic [31:0] want;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got event %0h, required no event", name, got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            errors++;
            $display("FAIL %s: got event %0h required %0h", name, got, want);
         end
      end
   endtask

   always @(negedge clk80) begin
      if (!reset) begin
         if (clear)              mon_ev("clear", ev(K_CLEAR, 28'(chip_hit)));
         if (pulse)              mon_ev("pulse", ev(K_PULSE, 28'(chip_hit)));
         if (cal)                mon_ev("cal",   ev(K_CAL, 28'({chip_hit, cal_data})));
         if (sync)               mon_ev("sync",  ev(K_SYNC, 28'd0));
         if (wr_valid)           mon_ev("wr",    ev(K_WR, 28'({wr_addr, wr_data})));
         if (rd_overflow)        mon_ev("rd_ovf", ev(K_OVF, 28'd0));
         if (rd_valid && rd_ready) mon_ev("rd_pop", ev(K_POP, 28'(rd_addr)));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      enc[0]  = 8'h6A; enc[1]  = 8'h6C; enc[2]  = 8'h71; enc[3]  = 8'h72;
      enc[4]  = 8'h74; enc[5]  = 8'h8B; enc[6]  = 8'h8D; enc[7]  = 8'h8E;
      enc[8]  = 8'h93; enc[9]  = 8'h95; enc[10] = 8'h96; enc[11] = 8'h99;
      enc[12] = 8'h9A; enc[13] = 8'h9C; enc[14] = 8'hA3; enc[15] = 8'hA5;
      enc[16] = 8'hA6; enc[17] = 8'hA9; enc[18] = 8'h59; enc[19] = 8'hAC;
      enc[20] = 8'hB1; enc[21] = 8'hB2; enc[22] = 8'hB4; enc[23] = 8'hC3;
      enc[24] = 8'hC5; enc[25] = 8'hC6; enc[26] = 8'hC9; enc[27] = 8'hCA;
      enc[28] = 8'hCC; enc[29] = 8'hD1; enc[30] = 8'hD2; enc[31] = 8'hD4;

      reset = 1'b1;
      idle(3);
      chk("rst_clear",    32'(clear), 0);
      chk("rst_pulse",    32'(pulse), 0);
      chk("rst_cal",      32'(cal), 0);
      chk("rst_sync",     32'(sync), 0);
      chk("rst_wr_valid", 32'(wr_valid), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_ovf",   32'(rd_overflow), 0);
      chk("rst_wr_addr",  32'(wr_addr), 0);
      chk("rst_wr_data",  32'(wr_data), 0);
      chk("rst_cal_data", 32'(cal_data), 0);
      chk("rst_rd_addr",  32'(rd_addr), 0);
      chk("rst_chip_hit", 32'(chip_hit), 0);
      chk("rst_err",      32'(err_count), 0);
      reset = 1'b0;
      idle(2);

      // G_PULSE repeated, ID 0, base 0 -> pulse next cycle, hit bit 0
      chip_id_base = 4'd0;
      expect_ev(K_PULSE, 28'h1);
      send(8'h5C, 0);
      send(8'h5C, 1);
      send(8'h6A, 0);
      chk("pulse_latency", 32'(pulse), 1);
      chk("pulse_hit",     32'(chip_hit), 32'h1);
      idle(3);

      // base 3: ID4 -> bit1; ID2 -> (2-3) mod 16 = 15, no hit, no error
      chip_id_base = 4'd3;
      expect_ev(K_CLEAR, 28'h2);
      send(8'h5A, 0);
      send(8'h74, 2);
      send(8'h5A, 1);
      send(8'h71, 3);
      chk("nohit_err", 32'(err_count), 0);
      chk("nohit_hit", 32'(chip_hit), 32'h2);

      // broadcast ID (bit4) -> all ones
      expect_ev(K_PULSE, 28'hF);
      send(8'h5C, 0);
      send(8'hA6, 2);

      // base 14, ID1 -> (1-14) mod 16 = 3 -> bit3
      chip_id_base = 4'd14;
      expect_ev(K_CLEAR, 28'h8);
      send(8'h5A, 1);
      send(8'h6C, 2);

      // CAL D1=5 D2=17 D3=31 -> cal_data 15'h163F
      chip_id_base = 4'd0;
      expect_ev(K_CAL, 28'({4'h1, 15'h163F}));
      send(8'h63, 1);
      send(8'h6A, 0);
      send(8'h8B, 2);
      send(8'hA9, 0);
      send(8'hD4, 3);
      chk("cal_data_held", 32'(cal_data), 32'h163F);

      // WRREG single, addr 0, data 817E = fields 16,5,31,0; random gaps 0-3
      expect_ev(K_WR, 28'({9'h000, 16'h817E}));
      send(8'h66, $urandom_range(0, 3));
      send(8'h6A, $urandom_range(0, 3));
      send(8'h6A, $urandom_range(0, 3));
      send(8'h6A, $urandom_range(0, 3));
      send(8'hA6, $urandom_range(0, 3));
      send(8'h8B, $urandom_range(0, 3));
      send(8'hD4, $urandom_range(0, 3));
      send(8'h6A, 3);
      chk("wr_addr_single", 32'(wr_addr), 0);
      chk("wr_data_single", 32'(wr_data), 32'h817E);

      // WRREG burst addr 1FF, N=1: 0887 @1FF then F800 @000
      expect_ev(K_WR, 28'({9'h1FF, 16'h0887}));
      expect_ev(K_WR, 28'({9'h000, 16'hF800}));
      send(8'h66, 0);
      send(8'h6A, 1);
      send(8'hD4, 0);
      send(8'hD4, 0);
      send(8'h6C, 1);
      send(8'h6C, 0);
      send(8'h71, 0);
      send(8'h72, 0);
      send(8'hA6, 0);
      send(8'hD4, 2);
      send(8'h6A, 0);
      send(8'h6A, 0);
      send(8'h6A, 3);

      // five RDREGs with rd_ready=0: fifth (155) dropped
      rd_ready = 1'b0;
      rd_frame(9, 3, 0);     // 123
      rd_frame(5, 5, 1);     // 0A5
      rd_frame(15, 31, 0);   // 1FF
      rd_frame(2, 0, 0);     // 040
      expect_ev(K_OVF, 28'd0);
      rd_frame(10, 21, 0);   // 155
      idle(3);
      chk("rdq_valid_full", 32'(rd_valid), 1);
      chk("rdq_head",       32'(rd_addr), 32'h123);
      expect_ev(K_POP, 28'h123);
      expect_ev(K_POP, 28'h0A5);
      expect_ev(K_POP, 28'h1FF);
      expect_ev(K_POP, 28'h040);
      rd_ready = 1'b1;
      idle(6);
      rd_ready = 1'b0;
      chk("rdq_drained", 32'(rd_valid), 0);

      // full FIFO, push and pop on the same edge: no overflow
      rd_frame(0, 1, 0);
      rd_frame(0, 2, 0);
      rd_frame(0, 3, 0);
      rd_frame(0, 4, 0);
      idle(2);
      send(8'h65, 0);
      send_d(0, 0);
      send_d(0, 0);
      expect_ev(K_POP, 28'h001);
      send_d(5, 0);
      rd_ready = 1'b1;
      idle(1);
      rd_ready = 1'b0;
      idle(3);
      expect_ev(K_POP, 28'h002);
      expect_ev(K_POP, 28'h003);
      expect_ev(K_POP, 28'h004);
      expect_ev(K_POP, 28'h005);
      rd_ready = 1'b1;
      idle(6);
      rd_ready = 1'b0;
      chk("rdq_drained2", 32'(rd_valid), 0);

      // sync, plain and with NOOP in between
      expect_ev(K_SYNC, 28'd0);
      expect_ev(K_SYNC, 28'd0);
      send(8'h81, 0);
      send(8'h7E, 2);
      send(8'h81, 1);
      send(8'hAA, 0);
      send(8'h7E, 2);
      chk("sync_err", 32'(err_count), 0);

      // 81 then 5A: one error, CLEAR frame still proceeds
      expect_ev(K_CLEAR, 28'h1);
      send(8'h81, 0);
      send(8'h5A, 0);
      send(8'h6A, 2);
      chk("sync_abort_err", 32'(err_count), 1);

      // error cases and NOOP mid-frame
      send(8'h00, 2);
      chk("idle_unknown_err", 32'(err_count), 2);
      expect_ev(K_PULSE, 28'h1);
      send(8'h66, 0);
      send(8'h6A, 0);
      send(8'h5C, 0);
      send(8'h6A, 2);
      chk("midframe_abort_err", 32'(err_count), 3);
      send(8'h5A, 0);
      send(8'h00, 2);
      chk("bad_id_err", 32'(err_count), 4);
      expect_ev(K_PULSE, 28'h1);
      send(8'h5C, 0);
      send(8'hAA, 1);
      send(8'h6A, 2);
      chk("noop_midframe_err", 32'(err_count), 4);

      // reset mid-frame: partial WRREG discarded, tail symbols are errors
      send(8'h66, 0);
      send(8'h6A, 0);
      send(8'h6A, 0);
      send(8'h6A, 0);
      send(8'h6C, 0);
      reset = 1'b1;
      idle(2);
      chk("midrst_err",  32'(err_count), 0);
      chk("midrst_hit",  32'(chip_hit), 0);
      reset = 1'b0;
      idle(1);
      send(8'h71, 0);
      send(8'h72, 0);
      send(8'hA6, 3);
      chk("postrst_err", 32'(err_count), 3);

      // saturation
      repeat (260) send(8'h00, 0);
      idle(2);
      chk("err_saturate", 32'(err_count), 32'hFF);

      idle(5);
      chk("exp_q_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
